// File: rtl/cipher_regfile_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : cipher_regfile_pkg                                      |
// | Description : Address map, FSM states and ID layout for the cipher   |
// |               key register file.                                      |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package cipher_regfile_pkg;

   localparam int unsigned ADDR_SELECT      = 'h00;
   localparam int unsigned ADDR_LOCK        = 'h02;
   localparam int unsigned ADDR_ID          = 'h04;
   localparam int unsigned ADDR_COMMIT      = 'h06;
   localparam int unsigned DEFAULT_KEY_BASE = 'h10;

   localparam int unsigned ID_SEL_LSB = 0;
   localparam int unsigned ID_CH_LSB  = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   // ID word: channel count in the upper byte, select width in the lower byte
   function automatic logic [15:0] id_word(input int unsigned num_ch, input int unsigned sel_width);
      logic [15:0] v;
      v = '0;
      v[ID_CH_LSB  +: 8] = num_ch[7:0];
      v[ID_SEL_LSB +: 8] = sel_width[7:0];
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cipher_key_slot.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : cipher_key_slot                                         |
// | Description : One key register with byte-strobed, lock-gated write.  |
// |               KEY_SHADOW_EN adds a shadow stage and commit copy.      |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module cipher_key_slot #(
   parameter int                   REG_WIDTH = 16,
   parameter logic [REG_WIDTH-1:0] RST_VAL   = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic                   locked,
   input  logic [REG_WIDTH-1:0]   wdata,
   input  logic [REG_WIDTH/8-1:0] wstrb,
`ifdef KEY_SHADOW_EN
   input  logic                   commit,
`endif
   output logic [REG_WIDTH-1:0]   key,
   output logic [REG_WIDTH-1:0]   rd_val
);

   localparam int c_NUM_BYTES = REG_WIDTH / 8;

   logic [REG_WIDTH-1:0] r_key;
   logic [REG_WIDTH-1:0] w_base;
   logic [REG_WIDTH-1:0] w_merged;

`ifdef KEY_SHADOW_EN
   logic [REG_WIDTH-1:0] r_shadow;

   assign w_base = r_shadow;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shadow <= RST_VAL;
         r_key    <= RST_VAL;
      end else begin
         if (wr_en && !locked) r_shadow <= w_merged;
         if (commit)           r_key    <= r_shadow;
      end
   end

   assign rd_val = r_shadow;
`else
   assign w_base = r_key;

   always_ff @(posedge clk) begin
      if (!rst_n)                r_key <= RST_VAL;
      else if (wr_en && !locked) r_key <= w_merged;
   end

   assign rd_val = r_key;
`endif

   always_comb begin
      w_merged = w_base;
      for (int b = 0; b < c_NUM_BYTES; b++) begin
         if (wstrb[b]) w_merged[b*8 +: 8] = wdata[b*8 +: 8];
      end
   end

   assign key = r_key;

endmodule
`default_nettype wire

// File: rtl/cipher_key_regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : cipher_key_regfile                                      |
// | Description : Cipher select / per-channel key register file with      |
// |               strobes, write locks, ID and a one-cycle response.      |
// |               Optional shadow keys with commit: KEY_SHADOW_EN.        |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module cipher_key_regfile
   import cipher_regfile_pkg::*;
#(
   parameter int                          ADDR_WIDTH = 8,
   parameter int                          REG_WIDTH  = 16,
   parameter int                          NUM_CH     = 3,
   parameter int                          SEL_WIDTH  = 2,
   parameter int unsigned                 KEY_BASE   = DEFAULT_KEY_BASE,
   parameter logic [NUM_CH*REG_WIDTH-1:0] KEY_RST    = {16'h0002, 16'hFFFF, 16'h0000}
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [ADDR_WIDTH-1:0]       addr,
   input  logic                        read,
   input  logic                        write,
   input  logic [REG_WIDTH-1:0]        wdata,
   input  logic [REG_WIDTH/8-1:0]      wstrb,
   output logic [REG_WIDTH-1:0]        rdata,
   output logic                        done,
   output logic                        error,
   output logic [REG_WIDTH-1:0]        select,
   output logic [NUM_CH*REG_WIDTH-1:0] keys,
   output logic [NUM_CH-1:0]           lock
);

   state_t                r_state, w_state_nxt;
   logic [SEL_WIDTH-1:0]  r_sel;
   logic [NUM_CH-1:0]     r_lock;
   logic [REG_WIDTH-1:0]  r_rdata;
   logic                  r_done, r_error;

   logic                  w_is_sel, w_is_lock, w_is_id, w_is_commit, w_valid;
   logic [NUM_CH-1:0]     w_key_hit;
   logic [REG_WIDTH-1:0]  w_key_rd [NUM_CH];
   logic [REG_WIDTH-1:0]  w_rd_val;
   logic                  w_access, w_err, w_wr_ok;

   always_comb begin
      w_is_sel    = (addr == ADDR_WIDTH'(ADDR_SELECT));
      w_is_lock   = (addr == ADDR_WIDTH'(ADDR_LOCK));
      w_is_id     = (addr == ADDR_WIDTH'(ADDR_ID));
`ifdef KEY_SHADOW_EN
      w_is_commit = (addr == ADDR_WIDTH'(ADDR_COMMIT));
`else
      w_is_commit = 1'b0;
`endif
      w_key_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (addr == ADDR_WIDTH'(KEY_BASE + 2 * i)) w_key_hit[i] = 1'b1;
      end
      w_valid = w_is_sel | w_is_lock | w_is_id | w_is_commit | (|w_key_hit);

      // COMMIT and invalid addresses fall through to zero
      w_rd_val = '0;
      if (w_is_sel)  w_rd_val = REG_WIDTH'(r_sel);
      if (w_is_lock) w_rd_val = REG_WIDTH'(r_lock);
      if (w_is_id)   w_rd_val = REG_WIDTH'(id_word(NUM_CH, SEL_WIDTH));
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_key_hit[i]) w_rd_val = w_key_rd[i];
      end
   end

   assign w_access = (r_state == IDLE) && (read || write);
   assign w_err    = (read && write) || !w_valid || (write && w_is_id)
                   || (write && |(w_key_hit & r_lock));
   assign w_wr_ok  = w_access && write && !w_err;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (read || write) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         r_rdata <= '0;
         r_sel   <= '0;
         r_lock  <= '0;
      end else begin
         r_done  <= w_access;
         r_error <= w_access && w_err;
         if (w_access && read) r_rdata <= w_err ? '0 : w_rd_val;
         if (w_wr_ok && w_is_sel) begin
            for (int b = 0; b < SEL_WIDTH; b++) begin
               if (wstrb[b/8]) r_sel[b] <= wdata[b];
            end
         end
         if (w_wr_ok && w_is_lock && wstrb[0]) r_lock <= r_lock | wdata[NUM_CH-1:0];
      end
   end

`ifdef KEY_SHADOW_EN
   logic [NUM_CH-1:0] w_commit;
   assign w_commit = (w_wr_ok && w_is_commit && wstrb[0]) ? wdata[NUM_CH-1:0] : '0;
`endif

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
      logic [REG_WIDTH-1:0] w_key;

      cipher_key_slot #(
         .REG_WIDTH (REG_WIDTH),
         .RST_VAL   (KEY_RST[gi*REG_WIDTH +: REG_WIDTH])
      ) u_slot (
         .clk    (clk),
         .rst_n  (rst_n),
         .wr_en  (w_wr_ok && w_key_hit[gi]),
         .locked (r_lock[gi]),
         .wdata  (wdata),
         .wstrb  (wstrb),
`ifdef KEY_SHADOW_EN
         .commit (w_commit[gi]),
`endif
         .key    (w_key),
         .rd_val (w_key_rd[gi])
      );

      assign keys[gi*REG_WIDTH +: REG_WIDTH] = w_key;
   end

   assign rdata  = r_rdata;
   assign done   = r_done;
   assign error  = r_error;
   assign select = REG_WIDTH'(r_sel);
   assign lock   = r_lock;

endmodule
`default_nettype wire
